prog_ctr: RTL and testbench
===========================

PROG_CTR -- requirements
Module: prog_ctr

Interface
REQ-001 SHALL have parameter D, default 12, meaning program counter and branch-target width in bits.
REQ-002 SHALL have parameter START_ADDR, default 0, meaning the PC value loaded on each Start.
REQ-003 SHALL have port Clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  level-sampled request to begin program execution.
REQ-006 SHALL have port Stall  input  1  hold PC for the current cycle.
REQ-007 SHALL have port BranchRel  input  1  take a PC-relative branch using Target.
REQ-008 SHALL have port Target  input  D  two's-complement relative offset from the branch-target LUT (e.g. +2, -2, +4, ..., -16).
REQ-009 SHALL have port BranchAbs  input  1  take an absolute jump to AbsAddr.
REQ-010 SHALL have port AbsAddr  input  D  absolute jump destination.
REQ-011 SHALL have port HaltReq  input  1  end-of-program indication from decode.
REQ-012 SHALL have port ProgCtr  output  D  current instruction address.
REQ-013 SHALL have port Running  output  1  high in RUN state.
REQ-014 SHALL have port Done  output  1  high in HALT state.
REQ-015 SHALL have port CycleCt  output  16  count of RUN-state cycles since last Start.

Function
REQ-016 SHALL implement three states: IDLE, RUN, HALT; Running = (state==RUN), Done = (state==HALT), both registered-state decodes.
REQ-017 IDLE: Start=1 -> RUN, ProgCtr <= START_ADDR, CycleCt <= 0; Start=0 -> stay, all outputs hold.
REQ-018 RUN: per-cycle priority HaltReq > Stall > BranchAbs > BranchRel > increment; exactly one action per edge.
REQ-019 RUN, HaltReq=1 -> HALT next edge; ProgCtr holds; CycleCt still increments for that cycle.
REQ-020 RUN, Stall=1 (no HaltReq) -> ProgCtr holds, CycleCt increments.
REQ-021 RUN, BranchAbs=1 -> ProgCtr <= AbsAddr.
REQ-022 RUN, BranchRel=1 (no BranchAbs) -> ProgCtr <= (ProgCtr + Target) mod 2^D, Target treated as signed.
REQ-023 RUN, no control asserted -> ProgCtr <= (ProgCtr + 1) mod 2^D.
REQ-024 Wrap-around SHALL be silent: 2^D-1 + 1 -> 0; 1 + (-2) -> 2^D-1; no error flag.
REQ-025 Start SHALL be ignored in RUN.
REQ-026 HALT: ProgCtr and CycleCt hold; Start=1 -> RUN with ProgCtr <= START_ADDR, CycleCt <= 0 (restart without Reset).
REQ-027 CycleCt SHALL increment by 1 every RUN-state edge and saturate at 16'hFFFF.
REQ-028 Branch/Stall/HaltReq inputs SHALL have no effect outside RUN.
REQ-029 Latency: control input sampled at edge N is reflected on ProgCtr/Done immediately after edge N; no combinational path from inputs to any output.

Reset
REQ-030 Reset=1 SHALL immediately (no clock required) force state=IDLE, ProgCtr=START_ADDR, CycleCt=0, Running=0, Done=0.
REQ-031 Reset asserted mid-RUN or in HALT SHALL abort to IDLE; Start sampled while Reset=1 SHALL be ignored.
REQ-032 After Reset deassert, first edge with Start=1 SHALL enter RUN.

Verification
REQ-033 Reset, Start pulse, 5 idle cycles -> ProgCtr 0,1,2,3,4,5; Running=1; CycleCt=5.
REQ-034 PC=10, BranchRel with Target=12'hFF0 (-16) -> PC=12'hFFA; then Target=+16 -> PC=10 (wrap both ways).
REQ-035 PC=4, BranchAbs=1 AbsAddr=100 and BranchRel=1 Target=+8 same cycle -> PC=100; Stall+BranchAbs same cycle -> PC holds.
REQ-036 PC=12'hFFF, no control -> PC=0; HaltReq at PC=7 -> Done=1 next edge, PC stays 7, Start then -> PC=0, CycleCt=0, Running=1.
REQ-037 Reset asserted asynchronously between edges during RUN at PC=33 -> ProgCtr=0, Running=0, Done=0 before next edge; remain IDLE until Start.
REQ-038 Run 70000 cycles with Stall=1 -> CycleCt saturates at 16'hFFFF, ProgCtr unchanged.

Source files
------------

// File: rtl/prog_ctr.sv
// Program counter sequencer with IDLE / RUN / HALT control.
// In RUN the PC advances, stalls, jumps or branches relative each cycle,
// with a saturating count of RUN cycles since the last Start.
// All outputs come straight from registers or from the state register,
// so there is no combinational path from any input to any output.

module prog_ctr #(
  parameter int          D          = 12,
  parameter int unsigned START_ADDR = 0
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Stall,
  input  logic         BranchRel,
  input  logic [D-1:0] Target,
  input  logic         BranchAbs,
  input  logic [D-1:0] AbsAddr,
  input  logic         HaltReq,
  output logic [D-1:0] ProgCtr,
  output logic         Running,
  output logic         Done,
  output logic [15:0]  CycleCt
);

  localparam logic [D-1:0] START_PC = D'(START_ADDR);
  localparam logic [15:0]  CYC_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // One action is chosen per RUN cycle; the ordering below is the priority.
  typedef enum logic [2:0] {
    ACT_HALT  = 3'd0,
    ACT_STALL = 3'd1,
    ACT_ABS   = 3'd2,
    ACT_REL   = 3'd3,
    ACT_INC   = 3'd4
  } action_t;

  state_t       state_q;
  state_t       state_d;
  logic [D-1:0] pc_q;
  logic [D-1:0] pc_d;
  logic [15:0]  cyc_q;
  logic [15:0]  cyc_d;
  action_t      action;
  logic [15:0]  cyc_inc;

  // Registers: reset drops everything back to IDLE at the start address.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cyc_q   <= cyc_d;
    end
  end

  // Pick the single RUN-cycle action by fixed priority.
  always_comb begin
    action = ACT_INC;
    if (HaltReq)
      action = ACT_HALT;
    else if (Stall)
      action = ACT_STALL;
    else if (BranchAbs)
      action = ACT_ABS;
    else if (BranchRel)
      action = ACT_REL;
  end

  // Next-state logic; Start only matters outside RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (Start) state_d = RUN;
      RUN:  if (action == ACT_HALT) state_d = HALT;
      HALT: if (Start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; a plain D-bit add wraps exactly like a signed
  // offset modulo 2^D, so Target needs no explicit sign extension.
  always_comb begin
    pc_d    = pc_q;
    cyc_d   = cyc_q;
    cyc_inc = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + 16'd1;
    case (state_q)
      IDLE, HALT: begin
        if (Start) begin
          pc_d  = START_PC;
          cyc_d = '0;
        end
      end
      RUN: begin
        cyc_d = cyc_inc;
        case (action)
          ACT_HALT:  pc_d = pc_q;
          ACT_STALL: pc_d = pc_q;
          ACT_ABS:   pc_d = AbsAddr;
          ACT_REL:   pc_d = pc_q + Target;
          default:   pc_d = pc_q + {{(D-1){1'b0}}, 1'b1};
        endcase
      end
      default: begin
        pc_d  = START_PC;
        cyc_d = '0;
      end
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    Running = (state_q == RUN);
    Done    = (state_q == HALT);
    ProgCtr = pc_q;
    CycleCt = cyc_q;
  end

endmodule

// File: tb/tb_prog_ctr.sv
// Scoreboard bench for prog_ctr: the driver updates an arithmetic model of
// the sequencer and queues the expected outputs; a monitor pops and compares
// after every clock edge and after every asynchronous reset assertion.
`timescale 1ns/1ps

module tb_prog_ctr;

  localparam int D          = 12;
  localparam int START_ADDR = 0;
  localparam int SPAN       = 1 << D;
  localparam int HALF       = 1 << (D-1);

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         Start = 1'b0;
  logic         Stall = 1'b0;
  logic         BranchRel = 1'b0;
  logic [D-1:0] Target = '0;
  logic         BranchAbs = 1'b0;
  logic [D-1:0] AbsAddr = '0;
  logic         HaltReq = 1'b0;
  logic [D-1:0] ProgCtr;
  logic         Running;
  logic         Done;
  logic [15:0]  CycleCt;

  prog_ctr #(.D(D), .START_ADDR(START_ADDR)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
    .BranchRel(BranchRel), .Target(Target), .BranchAbs(BranchAbs),
    .AbsAddr(AbsAddr), .HaltReq(HaltReq), .ProgCtr(ProgCtr),
    .Running(Running), .Done(Done), .CycleCt(CycleCt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [D-1:0] pc;
    logic         running;
    logic         done;
    logic [15:0]  cyc;
    int           step;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   step_no    = 0;
  bit   hold_reset = 1'b0;

  // Reference model: mode 0 = idle, 1 = running, 2 = halted.
  int m_mode = 0;
  int m_pc   = START_ADDR;
  int m_cyc  = 0;

  function automatic void model_reset();
    m_mode = 0;
    m_pc   = START_ADDR;
    m_cyc  = 0;
  endfunction

  function automatic void model_step(bit start, bit stall, bit brel,
                                     logic [D-1:0] target, bit babs,
                                     logic [D-1:0] abs, bit halt);
    int off;
    if (m_mode == 1) begin
      m_cyc = (m_cyc < 65535) ? m_cyc + 1 : 65535;
      if (halt) m_mode = 2;
      else if (stall) m_pc = m_pc;
      else if (babs) m_pc = int'(abs);
      else if (brel) begin
        off = int'(target);
        if (off >= HALF) off = off - SPAN;
        m_pc = (((m_pc + off) % SPAN) + SPAN) % SPAN;
      end else m_pc = (m_pc + 1) % SPAN;
    end else if (start) begin
      m_mode = 1;
      m_pc   = START_ADDR;
      m_cyc  = 0;
    end
  endfunction

  function automatic void push_expected();
    exp_t e;
    e.pc      = m_pc[D-1:0];
    e.running = (m_mode == 1);
    e.done    = (m_mode == 2);
    e.cyc     = m_cyc[15:0];
    e.step    = step_no;
    step_no++;
    sb.push_back(e);
  endfunction

  task automatic checkOutput(input exp_t e);
    compared++;
    if (ProgCtr !== e.pc) begin
      mismatched++;
      $display("[TB] FAIL pc step=%0d actual=%h required=%h", e.step, ProgCtr, e.pc);
    end
    compared++;
    if (Running !== e.running) begin
      mismatched++;
      $display("[TB] FAIL running step=%0d actual=%b required=%b", e.step, Running, e.running);
    end
    compared++;
    if (Done !== e.done) begin
      mismatched++;
      $display("[TB] FAIL done step=%0d actual=%b required=%b", e.step, Done, e.done);
    end
    compared++;
    if (CycleCt !== e.cyc) begin
      mismatched++;
      $display("[TB] FAIL cyclect step=%0d actual=%h required=%h", e.step, CycleCt, e.cyc);
    end
  endtask

  // One clock of stimulus: drive at the falling edge, update the model for
  // the coming rising edge, and queue what the DUT must show after it.
  task automatic applyStimulus(input bit start, input bit stall, input bit brel,
                               input logic [D-1:0] target, input bit babs,
                               input logic [D-1:0] abs, input bit halt);
    @(negedge Clk);
    Reset     = hold_reset;
    Start     = start;
    Stall     = stall;
    BranchRel = brel;
    Target    = target;
    BranchAbs = babs;
    AbsAddr   = abs;
    HaltReq   = halt;
    if (hold_reset) model_reset();
    else model_step(start, stall, brel, target, babs, abs, halt);
    push_expected();
  endtask

  task automatic idle(input bit start);
    applyStimulus(start, 0, 0, '0, 0, '0, 0);
  endtask

  task automatic jump(input logic [D-1:0] abs);
    applyStimulus(0, 0, 0, '0, 1, abs, 0);
  endtask

  task automatic rel(input logic [D-1:0] target);
    applyStimulus(0, 0, 1, target, 0, '0, 0);
  endtask

  // Assert reset between edges: one entry for the immediate effect, one for
  // the rising edge that follows while reset is still held.
  task automatic doReset();
    @(negedge Clk);
    #2;
    model_reset();
    push_expected();
    hold_reset = 1'b1;
    Reset = 1'b1;
    push_expected();
  endtask

  task automatic releaseReset();
    hold_reset = 1'b0;
  endtask

  // Monitor: compare after each rising clock edge and each reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk or posedge Reset);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog time limit expired, %0d entries pending", sb.size());
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit s, st, br, ba, h;
    logic [D-1:0] t, a;

    $display("[TB] reset and idle behaviour");
    doReset();
    applyStimulus(1, 1, 1, 12'h004, 1, 12'h055, 1);
    releaseReset();
    idle(0);
    applyStimulus(0, 1, 1, 12'h006, 1, 12'h077, 1);

    $display("[TB] start pulse then free run");
    idle(1);
    for (int i = 0; i < 5; i++) idle(0);

    $display("[TB] relative branch wrap both ways");
    jump(12'd10);
    rel(12'hFF0);
    rel(12'h010);

    $display("[TB] priority between controls");
    jump(12'd4);
    applyStimulus(0, 0, 1, 12'h008, 1, 12'd100, 0);
    applyStimulus(0, 1, 0, '0, 1, 12'd200, 0);
    applyStimulus(1, 0, 0, '0, 0, '0, 0);

    $display("[TB] increment wrap, halt and restart");
    jump(12'hFFF);
    idle(0);
    jump(12'd7);
    applyStimulus(0, 0, 1, 12'h002, 1, 12'd50, 1);
    applyStimulus(0, 1, 1, 12'h002, 1, 12'd50, 1);
    applyStimulus(0, 0, 0, '0, 1, 12'd50, 0);
    idle(1);
    idle(0);

    $display("[TB] asynchronous reset mid-run");
    jump(12'd33);
    doReset();
    idle(1);
    releaseReset();
    idle(0);
    idle(0);
    idle(1);
    idle(0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 2000; i++) begin
      if (!hold_reset && ($urandom % 150 == 0)) begin
        doReset();
      end else if (hold_reset && ($urandom % 2 == 0)) begin
        releaseReset();
      end
      s  = ($urandom % 8 == 0);
      h  = ($urandom % 16 == 0);
      st = ($urandom % 5 == 0);
      ba = ($urandom % 6 == 0);
      br = ($urandom % 3 == 0);
      if ($urandom % 2 == 0) t = D'($urandom);
      else t = D'(($urandom_range(1, 8) * 2) * (($urandom % 2) ? 1 : -1));
      a = D'($urandom);
      applyStimulus(s, st, br, t, ba, a, h);
    end
    releaseReset();
    idle(0);

    $display("[TB] long stall, cycle counter saturation");
    doReset();
    releaseReset();
    idle(1);
    jump(12'h123);
    for (int i = 0; i < 70000; i++) begin
      applyStimulus($urandom % 2, 1, $urandom % 2, D'($urandom), $urandom % 2, D'($urandom), 0);
    end
    idle(0);
    idle(0);

    @(posedge Clk);
    #3;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain pending=%0d required=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
